// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines x 16-byte blocks, 1 KiB instruction space.
// Hit: 0 cycles. Miss: BUSYWAIT stalls for N+3 cycles, where N is the number of memory busy cycles.
module instruction_cache (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [31:0]   PC,
   output logic [31:0]   INSTRUCTION,
   output logic          BUSYWAIT,
   output logic          MEM_READ,
   output logic [5:0]    MEM_ADDRESS,
   input  logic [127:0]  MEM_READDATA,
   input  logic          MEM_BUSYWAIT
);

   typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

   state_t         r_state;
   logic [7:0]     r_valid;
   logic [2:0]     r_tag  [8];
   logic [127:0]   r_data [8];
   logic [5:0]     r_mem_addr;
   logic           r_mem_read;

   logic [2:0]     w_index;
   logic [2:0]     w_tag;
   logic [1:0]     w_offset;
   logic [127:0]   w_line;
   logic [31:0]    w_word;
   logic           w_hit;
   logic           w_fill;
   logic           w_unused;

   assign w_offset = PC[3:2];
   assign w_index  = PC[6:4];
   assign w_tag    = PC[9:7];
   assign w_unused = ^{PC[31:10], PC[1:0]};

   assign w_line = r_data[w_index];
   assign w_word = w_line[32*w_offset +: 32];
   assign w_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_fill = RESET && (r_state == S_MEM_READ) && !MEM_BUSYWAIT;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_mem_addr <= '0;
         r_mem_read <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_hit) begin
                  r_mem_addr <= PC[9:4];
                  r_mem_read <= 1'b1;
                  r_state    <= S_MEM_READ;
               end
            end
            S_MEM_READ: begin
               if (!MEM_BUSYWAIT) begin
                  r_valid[r_mem_addr[2:0]] <= 1'b1;
                  r_mem_read               <= 1'b0;
                  r_state                  <= S_UPDATE;
               end
            end
            S_UPDATE: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   // Tag and data carry no reset; the valid bit alone guards them.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_data[r_mem_addr[2:0]] <= MEM_READDATA;
         r_tag[r_mem_addr[2:0]]  <= r_mem_addr[5:3];
      end
   end

   always_comb begin
      INSTRUCTION = '0;
      BUSYWAIT    = 1'b0;
      if (RESET) begin
         if (r_state == S_IDLE) begin
            BUSYWAIT    = !w_hit;
            INSTRUCTION = w_hit ? w_word : '0;
         end else begin
            BUSYWAIT    = 1'b1;
         end
      end
   end

   assign MEM_READ    = r_mem_read;
   assign MEM_ADDRESS = r_mem_addr;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: hit vectors from a table, hand-written miss/reset sequences.
module tb_instruction_cache;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [31:0]   PC;
   logic [31:0]   INSTRUCTION;
   logic          BUSYWAIT;
   logic          MEM_READ;
   logic [5:0]    MEM_ADDRESS;
   logic [127:0]  MEM_READDATA;
   logic          MEM_BUSYWAIT;

   int n_cmp = 0;
   int n_bad = 0;
   int lat   = 0;
   int mcnt  = 0;

   instruction_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .PC           (PC),
      .INSTRUCTION  (INSTRUCTION),
      .BUSYWAIT     (BUSYWAIT),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   // Block 0 holds the reference program; other blocks are tagged with their address.
   function automatic logic [127:0] blk(input logic [5:0] a);
      logic [127:0] b;
      if (a == 6'd0) begin
         b = {32'h05020301, 32'h02040201, 32'h00010007, 32'h00000005};
      end else begin
         for (int k = 0; k < 4; k++)
            b[32*k +: 32] = 32'hA000_0000 | (32'(a) << 8) | 32'(k);
      end
      return b;
   endfunction

   assign MEM_READDATA = blk(MEM_ADDRESS);

   // Memory stays busy for 'lat' cycles of MEM_READ, then completes.
   always @(negedge CLK) begin
      if (MEM_READ) mcnt = mcnt + 1;
      else          mcnt = 0;
      MEM_BUSYWAIT = MEM_READ ? (mcnt <= lat) : 1'b1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called right after a falling edge: presents pc and follows the stall to its end.
   task automatic fetch(input string nm, input logic [31:0] pc, input int l,
                        input int eb, input int emr, input logic [5:0] ea,
                        input logic [31:0] ei);
      int nb = 0;
      int nr = 0;
      int bad_addr = 0;
      bit done = 1'b0;
      PC  = pc;
      lat = l;
      for (int c = 0; c < 100 && !done; c++) begin
         #2;
         if (BUSYWAIT) begin
            nb++;
            if (MEM_READ) begin
               nr++;
               if (MEM_ADDRESS !== ea) bad_addr++;
            end
            @(negedge CLK);
         end else begin
            done = 1'b1;
         end
      end
      check({nm, "_done"},      32'(done), 32'd1);
      check({nm, "_busy_cyc"},  nb, eb);
      check({nm, "_read_cyc"},  nr, emr);
      check({nm, "_addr_bad"},  bad_addr, 0);
      check({nm, "_read_end"},  32'(MEM_READ), 32'd0);
      check({nm, "_instr"},     INSTRUCTION, ei);
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        busy;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{32'h0000_0004, 32'h00010007, 1'b0};
      vecs[1] = '{32'h0000_0008, 32'h02040201, 1'b0};
      vecs[2] = '{32'h0000_000C, 32'h05020301, 1'b0};
      vecs[3] = '{32'h0000_0400, 32'h00000005, 1'b0};
      vecs[4] = '{32'h0000_0002, 32'h00000005, 1'b0};
      vecs[5] = '{32'hFFFF_FC0C, 32'h05020301, 1'b0};

      RESET = 1'b1;
      PC    = 32'h0;
      MEM_BUSYWAIT = 1'b1;

      // Reset asserted mid-cycle forces outputs low at once
      #3 RESET = 1'b0;
      #1;
      check("rst_mem_read", 32'(MEM_READ), 32'd0);
      check("rst_busywait", 32'(BUSYWAIT), 32'd0);
      check("rst_instr",    INSTRUCTION,   32'd0);
      check("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      fetch("cold", 32'h000, 4, 7, 5, 6'h00, 32'h00000005);

      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         PC = vecs[i].pc;
         #2;
         check($sformatf("vec%0d_instr", i), INSTRUCTION, vecs[i].instr);
         check($sformatf("vec%0d_busy", i),  32'(BUSYWAIT), 32'(vecs[i].busy));
         check($sformatf("vec%0d_mread", i), 32'(MEM_READ), 32'd0);
      end

      @(negedge CLK);
      fetch("conflict", 32'h080, 2, 5, 3, 6'h08, 32'hA0000800);
      @(negedge CLK);
      PC = 32'h08C;
      #2;
      check("conflict_w3_instr", INSTRUCTION, 32'hA0000803);
      check("conflict_w3_busy",  32'(BUSYWAIT), 32'd0);
      @(negedge CLK);
      fetch("refill0", 32'h000, 0, 3, 1, 6'h00, 32'h00000005);

      // Abort a long fetch with reset
      @(negedge CLK);
      PC  = 32'h010;
      lat = 20;
      repeat (3) @(posedge CLK);
      #3;
      check("abort_pre_mread", 32'(MEM_READ), 32'd1);
      RESET = 1'b0;
      #1;
      check("abort_mread", 32'(MEM_READ), 32'd0);
      check("abort_busy",  32'(BUSYWAIT), 32'd0);
      check("abort_instr", INSTRUCTION,   32'd0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      fetch("after_abort", 32'h010, 1, 4, 2, 6'h01, 32'hA0000100);
      @(negedge CLK);
      fetch("stale0", 32'h000, 0, 3, 1, 6'h00, 32'h00000005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
